// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encoding, guard-bit count and the arctangent
// table generator used to parameterise each micro-rotation stage.
package cordic_pkg;

  localparam int   GUARD    = 2;
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam real PI = 3.14159265358979323846;

  // atan(2^-idx) in binary radians (full circle = 2^width), evaluated at
  // elaboration with a Taylor series so no real math reaches hardware.
  function automatic int atan_val(input int width, input int idx);
    real scale;
    real t;
    real term;
    real sum;
    real sgn;
    scale = 1.0;
    for (int k = 0; k < width; k++) scale = scale * 2.0;
    if (idx == 0) return $rtoi(scale / 8.0 + 0.5);
    t = 1.0;
    for (int k = 0; k < idx; k++) t = t / 2.0;
    sum  = 0.0;
    term = t;
    sgn  = 1.0;
    for (int k = 0; k < 40; k++) begin
      sum  = sum + sgn * term / real'(2 * k + 1);
      term = term * t * t;
      sgn  = -sgn;
    end
    return $rtoi(sum * scale / (2.0 * PI) + 0.5);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: shift-add on x/y and a fixed arctangent
// step on z, direction chosen by the sample's own mode.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            i_en,
  input  logic                            i_valid,
  input  logic                            i_mode,
  input  logic signed [WIDTH+GUARD-1:0]   i_x,
  input  logic signed [WIDTH+GUARD-1:0]   i_y,
  input  logic        [WIDTH-1:0]         i_z,
  output logic                            o_valid,
  output logic                            o_mode,
  output logic signed [WIDTH+GUARD-1:0]   o_x,
  output logic signed [WIDTH+GUARD-1:0]   o_y,
  output logic        [WIDTH-1:0]         o_z
);

  localparam int              IW     = WIDTH + GUARD;
  localparam logic [WIDTH-1:0] ATAN_W = WIDTH'(ATAN);

  logic                 w_neg;
  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;

  // Rotation drives the residual angle to zero; vectoring drives y to zero.
  assign w_neg = (i_mode == MODE_ROT) ? i_z[WIDTH-1] : ~i_y[IW-1];
  assign w_xs  = i_x >>> SHIFT;
  assign w_ys  = i_y >>> SHIFT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_mode  <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_mode  <= i_mode;
      if (w_neg) begin
        o_x <= i_x + w_ys;
        o_y <= i_y - w_xs;
        o_z <= i_z + ATAN_W;
      end else begin
        o_x <= i_x - w_ys;
        o_y <= i_y + w_xs;
        o_z <= i_z - ATAN_W;
      end
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Pipelined CORDIC engine: quadrant pre-rotation, ITER micro-rotation stages and
// a saturating output register, all advancing together under one stall signal.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] z0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam int               IW      = WIDTH + GUARD;
  localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

  logic                 w_advance;
  logic signed [IW-1:0] w_xe;
  logic signed [IW-1:0] w_ye;
  logic signed [IW-1:0] w_preX;
  logic signed [IW-1:0] w_preY;
  logic [WIDTH-1:0]     w_preZ;

  logic                 r_preValid;
  logic                 r_preMode;
  logic signed [IW-1:0] r_preX;
  logic signed [IW-1:0] r_preY;
  logic [WIDTH-1:0]     r_preZ;

  logic                 w_valid [0:ITER];
  logic                 w_mode  [0:ITER];
  logic signed [IW-1:0] w_x     [0:ITER];
  logic signed [IW-1:0] w_y     [0:ITER];
  logic [WIDTH-1:0]     w_z     [0:ITER];

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_xe = {{GUARD{x0[WIDTH-1]}}, x0};
  assign w_ye = {{GUARD{y0[WIDTH-1]}}, y0};

  // Fold the vector into the right half-plane so the stages only need to cover +/-90 deg.
  always_comb begin
    w_preX = w_xe;
    w_preY = w_ye;
    w_preZ = z0;
    if (in_mode == MODE_ROT) begin
      case (z0[WIDTH-1 -: 2])
        2'b01: begin
          w_preX = -w_ye;
          w_preY = w_xe;
          w_preZ = z0 - QUARTER;
        end
        2'b10: begin
          w_preX = w_ye;
          w_preY = -w_xe;
          w_preZ = z0 + QUARTER;
        end
        default: ;
      endcase
    end else if (x0[WIDTH-1]) begin
      if (!y0[WIDTH-1]) begin
        w_preX = w_ye;
        w_preY = -w_xe;
        w_preZ = z0 + QUARTER;
      end else begin
        w_preX = -w_ye;
        w_preY = w_xe;
        w_preZ = z0 - QUARTER;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_preValid <= 1'b0;
      r_preMode  <= 1'b0;
      r_preX     <= '0;
      r_preY     <= '0;
      r_preZ     <= '0;
    end else if (w_advance) begin
      r_preValid <= in_valid;
      r_preMode  <= in_mode;
      r_preX     <= w_preX;
      r_preY     <= w_preY;
      r_preZ     <= w_preZ;
    end
  end

  assign w_valid[0] = r_preValid;
  assign w_mode[0]  = r_preMode;
  assign w_x[0]     = r_preX;
  assign w_y[0]     = r_preY;
  assign w_z[0]     = r_preZ;

  for (genvar k = 0; k < ITER; k++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .SHIFT (k),
      .ATAN  (atan_val(WIDTH, k))
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_en    (w_advance),
      .i_valid (w_valid[k]),
      .i_mode  (w_mode[k]),
      .i_x     (w_x[k]),
      .i_y     (w_y[k]),
      .i_z     (w_z[k]),
      .o_valid (w_valid[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_x     (w_x[k+1]),
      .o_y     (w_y[k+1]),
      .o_z     (w_z[k+1])
    );
  end

  // Clamp when the guard bits disagree with the port sign bit.
  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v[IW-1:WIDTH-1] == {(GUARD+1){v[IW-1]}}) return v[WIDTH-1:0];
    else if (v[IW-1]) return {1'b1, {(WIDTH-1){1'b0}}};
    else return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (w_advance) begin
      out_valid <= w_valid[ITER];
      out_mode  <= w_mode[ITER];
      x_out     <= sat(w_x[ITER]);
      y_out     <= sat(w_y[ITER]);
      z_out     <= w_z[ITER];
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: a plain-arithmetic CORDIC reference model
// feeds an expected-result queue that an independent output monitor drains.
module tb_cordic_engine;

  localparam int W    = 16;
  localparam int ITER = 15;

  logic         clock     = 1'b0;
  logic         reset_n   = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_mode   = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x0 = '0;
  logic [W-1:0] y0 = '0;
  logic [W-1:0] z0 = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_mode;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;

  cordic_engine #(.WIDTH(W), .ITER(ITER)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .x0        (x0),
    .y0        (y0),
    .z0        (z0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  atanTab[ITER];
  bit  drvDone;

  // Ideal arctangent table from real math, rounded to the nearest binary-radian unit.
  task automatic buildAtanTable();
    real t;
    t = 1.0;
    for (int i = 0; i < ITER; i++) begin
      atanTab[i] = $rtoi($atan(t) * (2.0 ** W) / (2.0 * 3.14159265358979) + 0.5);
      t = t / 2.0;
    end
  endtask

  // Reference: quadrant fold, ITER shift-add rotations on unbounded integers, clamp.
  function automatic expT model(input logic m, input logic [W-1:0] xi, input logic [W-1:0] yi,
                                input logic [W-1:0] zi);
    longint x, y, z, t, xs, ys;
    longint full, half, quarter;
    bit     neg;
    expT    r;
    full    = longint'(1) << W;
    half    = longint'(1) << (W - 1);
    quarter = longint'(1) << (W - 2);
    x = longint'($signed(xi));
    y = longint'($signed(yi));
    z = longint'(zi);
    if (m == 1'b0) begin
      if (z >= quarter && z < half) begin
        t = x; x = -y; y = t; z = z - quarter;
      end else if (z >= half && z < half + quarter) begin
        t = x; x = y; y = -t; z = z + quarter;
      end
    end else if (x < 0) begin
      if (y >= 0) begin
        t = x; x = y; y = -t; z = z + quarter;
      end else begin
        t = x; x = -y; y = t; z = z - quarter;
      end
    end
    z = ((z % full) + full) % full;
    for (int i = 0; i < ITER; i++) begin
      neg = (m == 1'b0) ? (z >= half) : (y >= 0);
      xs  = x >>> i;
      ys  = y >>> i;
      if (neg) begin
        x = x + ys; y = y - xs; z = z + atanTab[i];
      end else begin
        x = x - ys; y = y + xs; z = z - atanTab[i];
      end
      z = ((z % full) + full) % full;
    end
    if (x > half - 1) x = half - 1;
    if (x < -half)    x = -half;
    if (y > half - 1) y = half - 1;
    if (y < -half)    y = -half;
    r.mode = m;
    r.x    = W'(x);
    r.y    = W'(y);
    r.z    = W'(z);
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=[%0d..%0d] t=%0t", name, act, lo, hi, $time);
    end
  endtask

  // Present one sample from posedge+1 until accepted; the expectation is queued at acceptance.
  task automatic applyStimulus(input logic m, input logic [W-1:0] xi, input logic [W-1:0] yi,
                               input logic [W-1:0] zi);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    x0 = xi;
    y0 = yi;
    z0 = zi;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clock);
      if (in_ready && reset_n) begin
        acc = 1'b1;
        expQ.push_back(model(m, xi, yi, zi));
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted t=%0t", $time);
    end
  endtask

  task automatic directed(input string name, input logic m, input int xi, input int yi, input int zi,
                          input int xlo, input int xhi, input int ylo, input int yhi,
                          input int zlo, input int zhi);
    int cnt;
    applyStimulus(m, W'(xi), W'(yi), W'(zi));
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    checkOutput({name, ".latency"}, cnt, ITER + 1, ITER + 1);
    checkOutput({name, ".x"}, longint'($signed(x_out)), xlo, xhi);
    checkOutput({name, ".y"}, longint'($signed(y_out)), ylo, yhi);
    checkOutput({name, ".z"}, longint'($signed(z_out)), zlo, zhi);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && expQ.size() != 0; n++) @(posedge clock);
    #1;
    checkOutput({name, ".drain_left"}, expQ.size(), 0, 0);
  endtask

  // Monitor: pops on each completed output handshake, checks hold behaviour while stalled.
  initial begin : monitor
    bit     held;
    longint hv;
    expT    e;
    held = 1'b0;
    hv   = 0;
    forever begin
      @(negedge clock);
      if (!reset_n || !out_valid) begin
        held = 1'b0;
      end else begin
        if (held)
          checkOutput("stall.stable", longint'({out_mode, x_out, y_out, z_out}), hv, hv);
        if (!out_ready) begin
          checkOutput("stall.in_ready", longint'(in_ready), 0, 0);
          hv   = longint'({out_mode, x_out, y_out, z_out});
          held = 1'b1;
        end else begin
          held = 1'b0;
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb.unexpected actual=output required=none x=%0d t=%0t",
                     $signed(x_out), $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb.mode", longint'(out_mode), longint'(e.mode), longint'(e.mode));
            checkOutput("sb.x", longint'($signed(x_out)), longint'($signed(e.x)), longint'($signed(e.x)));
            checkOutput("sb.y", longint'($signed(y_out)), longint'($signed(e.y)), longint'($signed(e.y)));
            checkOutput("sb.z", longint'(z_out), longint'(e.z), longint'(e.z));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int  n;
    bit  seen;
    buildAtanTable();

    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst.out_valid", longint'(out_valid), 0, 0);
    checkOutput("rst.in_ready", longint'(in_ready), 1, 1);
    checkOutput("rst.out_mode", longint'(out_mode), 0, 0);
    checkOutput("rst.x_out", longint'(x_out), 0, 0);
    checkOutput("rst.y_out", longint'(y_out), 0, 0);
    checkOutput("rst.z_out", longint'(z_out), 0, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    directed("rot45", 1'b0, 19898, 0, 8192, 23162, 23178, 23162, 23178, -4, 4);
    directed("rot135", 1'b0, 19898, 0, 24576, -23178, -23162, 23162, 23178, -4, 4);
    directed("vec", 1'b1, -10000, 10000, 0, 23279, 23299, -8, 8, 24572, 24580);
    directed("sat", 1'b0, 32767, 32767, 8192, -32768, 32767, 32767, 32767, -32768, 32767);
    drain("directed");

    // Alternating modes back-to-back with a 5-cycle downstream stall mid-stream.
    fork
      begin
        for (int k = 0; k < 16; k++)
          applyStimulus(logic'(k % 2), W'($urandom), W'($urandom), W'($urandom));
      end
      begin
        repeat (20) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall");

    drvDone = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
          applyStimulus(logic'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom));
        end
        drvDone = 1'b1;
      end
      begin
        while (!drvDone) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("random");

    // Asynchronous reset with eight samples in flight and a result held at the output.
    out_ready = 1'b0;
    applyStimulus(1'b1, W'(-12000), W'(5000), W'(0));
    for (int k = 1; k < 8; k++)
      applyStimulus(logic'(k % 2), W'($urandom), W'($urandom), W'($urandom));
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("rst2.setup_valid", longint'(out_valid), 1, 1);
    checkOutput("rst2.setup_mode", longint'(out_mode), 1, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst2.out_valid", longint'(out_valid), 0, 0);
    checkOutput("rst2.out_mode", longint'(out_mode), 0, 0);
    checkOutput("rst2.x_out", longint'(x_out), 0, 0);
    checkOutput("rst2.y_out", longint'(y_out), 0, 0);
    checkOutput("rst2.z_out", longint'(z_out), 0, 0);
    checkOutput("rst2.in_ready", longint'(in_ready), 1, 1);
    expQ.delete();
    repeat (3) @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("rst2.no_stale", longint'(seen), 0, 0);

    @(posedge clock);
    #1;
    directed("post_rst", 1'b0, 19898, 0, 8192, 23162, 23178, 23162, 23178, -4, 4);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
